// File: rtl/ioctl_dn_buffer.sv
// ioctl_dn_buffer
//   Download-side adapter between the HPS ioctl byte stream and the core's
//   download port. Incoming bytes are queued in a small FIFO, the HPS is
//   throttled with ioctl_wait as the FIFO fills, and bytes are replayed to the
//   core whenever it reports dn_ready. dn_busy holds the core in reset from
//   download start until the last buffered byte has been written.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 4)
//   WAIT_THRESH  occupancy at which ioctl_wait asserts (1..DEPTH-2)
//
// Ports
//   clk_sys, reset_n      clock, asynchronous active-low reset
//   ioctl_download        HPS download-active level
//   ioctl_wr              single-cycle byte strobe
//   ioctl_addr[24:0]      byte address (only [13:0] is addressable)
//   ioctl_dout[7:0]       byte data
//   ioctl_index[7:0]      download target index
//   ioctl_wait            registered back-pressure to the HPS
//   dn_addr/dn_data       registered core write address/data
//   dn_index              index latched at download start
//   dn_wr                 one-cycle core write strobe per byte
//   dn_ready              core can accept a write this cycle
//   dn_busy               high from download start until the FIFO has drained
//   dn_done               one-cycle completion pulse
//   dn_count              bytes delivered in the current/last download
//   dn_overflow           sticky: byte dropped because the FIFO was full
//   dn_range_err          sticky: byte dropped because ioctl_addr[24:14] != 0
//
// Core handshake: a byte is popped in any cycle where the FIFO is non-empty
// and dn_ready is high; the popped entry appears on dn_addr/dn_data together
// with dn_wr in the following cycle. dn_wr is never held waiting on dn_ready.
module ioctl_dn_buffer #(
    parameter int DEPTH       = 8,
    parameter int WAIT_THRESH = 6
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [7:0]  dn_index,
    output logic        dn_wr,
    input  logic        dn_ready,
    output logic        dn_busy,
    output logic        dn_done,
    output logic [15:0] dn_count,
    output logic        dn_overflow,
    output logic        dn_range_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_WAIT = OW'(WAIT_THRESH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          dl_prev_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d;
    logic [21:0]   mem [DEPTH];

    logic dl_rise, wr_req, range_bad, full, push, pop, drop_ovf, drop_rng;

    // dl_prev_q resets high so a download already in progress when reset
    // releases is not mistaken for a fresh start.
    assign dl_rise   = ioctl_download & ~dl_prev_q;
    assign range_bad = |ioctl_addr[24:14];
    assign wr_req    = ioctl_wr & ioctl_download & ((state_q == S_LOAD) | dl_rise);
    assign full      = (occ_q == OCC_FULL);
    assign pop       = (occ_q != '0) & dn_ready;
    // A push into a full FIFO is fine when a pop frees a slot this cycle.
    assign push      = wr_req & ~range_bad & (~full | pop);
    assign drop_ovf  = wr_req & ~range_bad & full & ~pop;
    assign drop_rng  = wr_req & range_bad;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dl_rise) state_d = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_d = S_DRAIN;
            // Empty FIFO means nothing can be popped, so the strobe currently
            // on dn_wr (if any) is the last one.
            S_DRAIN: if (dl_rise) state_d = S_LOAD;
                     else if (occ_q == '0) state_d = S_DONE;
            S_DONE:  state_d = dl_rise ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is not reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr_q] <= {ioctl_addr[13:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            dl_prev_q    <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ioctl_wait   <= 1'b0;
            dn_addr      <= '0;
            dn_data      <= '0;
            dn_index     <= '0;
            dn_wr        <= 1'b0;
            dn_busy      <= 1'b0;
            dn_done      <= 1'b0;
            dn_count     <= '0;
            dn_overflow  <= 1'b0;
            dn_range_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_prev_q  <= ioctl_download;
            occ_q      <= occ_d;
            ioctl_wait <= (occ_d >= OCC_WAIT);
            dn_wr      <= pop;
            dn_busy    <= (state_d == S_LOAD) || (state_d == S_DRAIN);
            dn_done    <= (state_d == S_DONE);

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                {dn_addr, dn_data} <= mem[rd_ptr_q];
            end

            if (dl_rise) dn_index <= ioctl_index;

            if (dl_rise)
                dn_count <= {15'd0, pop};
            else if (pop && dn_count != 16'hFFFF)
                dn_count <= dn_count + 16'd1;

            // Setting wins over the start-of-download clear so a bad byte in
            // the very first cycle is still reported.
            if (drop_ovf)     dn_overflow <= 1'b1;
            else if (dl_rise) dn_overflow <= 1'b0;

            if (drop_rng)     dn_range_err <= 1'b1;
            else if (dl_rise) dn_range_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ioctl_dn_buffer.sv
module tb_ioctl_dn_buffer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic [7:0]  dn_index;
    logic        dn_wr;
    logic        dn_ready = 1'b0;
    logic        dn_busy;
    logic        dn_done;
    logic [15:0] dn_count;
    logic        dn_overflow;
    logic        dn_range_err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [21:0] exp_q[$];

    ioctl_dn_buffer #(.DEPTH(8), .WAIT_THRESH(6)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
        .dn_wr(dn_wr), .dn_ready(dn_ready), .dn_busy(dn_busy),
        .dn_done(dn_done), .dn_count(dn_count),
        .dn_overflow(dn_overflow), .dn_range_err(dn_range_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_sys = ~clk_sys;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    logic done_prev = 1'b0;
    always @(negedge clk_sys) begin
        logic [21:0] exp_v;
        if (dn_wr) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL dn_wr_unexpected: got addr=%0h data=%0h, required no write",
                         dn_addr, dn_data);
            end else begin
                exp_v = exp_q.pop_front();
                if ({dn_addr, dn_data} !== exp_v) begin
                    fails++;
                    $display("FAIL dn_wr_payload: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             dn_addr, dn_data, exp_v[21:8], exp_v[7:0]);
                end
            end
        end
        if (dn_done) begin
            done_cnt++;
            tests++;
            if (done_prev) begin
                fails++;
                $display("FAIL dn_done_width: got 2+ cycles, required 1");
            end
        end
        done_prev = dn_done;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        step();
    endtask

    // One strobe; consecutive calls give back-to-back strobes.
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_store);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (expect_store) exp_q.push_back({a[13:0], d});
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start_cnt = done_cnt;
        int n = 0;
        while (done_cnt == start_cnt && n < 200) begin
            step();
            n++;
        end
        if (done_cnt == start_cnt) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no dn_done in 200 cycles, required 1 pulse", name);
        end
        step(3);
        chk({name, "_done_pulses"}, done_cnt - start_cnt, 1);
        chk({name, "_busy_after"}, dn_busy, 0);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_wait"}, ioctl_wait, 0);
        chk({name, "_wr"}, dn_wr, 0);
        chk({name, "_addr"}, dn_addr, 0);
        chk({name, "_data"}, dn_data, 0);
        chk({name, "_index"}, dn_index, 0);
        chk({name, "_busy"}, dn_busy, 0);
        chk({name, "_done"}, dn_done, 0);
        chk({name, "_count"}, dn_count, 0);
        chk({name, "_ovf"}, dn_overflow, 0);
        chk({name, "_rng"}, dn_range_err, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        chk_zero("reset");
        reset_n = 1'b1;
        step(2);

        // Basic transfer: 16 bytes, index 0x01
        dn_ready = 1'b1;
        start_dl(8'h01);
        chk("basic_busy_start", dn_busy, 1);
        for (int i = 0; i < 16; i++) wr_byte(25'(i), 8'(8'hA0 + i), 1'b1);
        end_dl();
        wait_done("basic");
        chk("basic_index", dn_index, 8'h01);
        chk("basic_count", dn_count, 16);

        // Back-pressure: 6 bytes with dn_ready low
        dn_ready = 1'b0;
        start_dl(8'h02);
        for (int i = 0; i < 5; i++) wr_byte(25'(16'h0100 + i), 8'(8'h30 + i), 1'b1);
        chk("bp_wait_at5", ioctl_wait, 0);
        wr_byte(25'h0105, 8'h35, 1'b1);
        chk("bp_wait_at6", ioctl_wait, 1);
        step();
        chk("bp_wait_hold", ioctl_wait, 1);
        dn_ready = 1'b1;
        step();
        chk("bp_wait_drop", ioctl_wait, 0);
        step(8);
        end_dl();
        wait_done("bp");
        chk("bp_count", dn_count, 6);

        // Overflow: 9 strobes into an 8-entry FIFO
        dn_ready = 1'b0;
        start_dl(8'h03);
        for (int i = 0; i < 9; i++) wr_byte(25'(16'h0200 + i), 8'(8'h50 + i), i < 8);
        chk("ovf_flag", dn_overflow, 1);
        chk("ovf_wait", ioctl_wait, 1);
        dn_ready = 1'b1;
        end_dl();
        wait_done("ovf");
        chk("ovf_count", dn_count, 8);
        chk("ovf_sticky", dn_overflow, 1);

        // Range error: 0x4000 among valid bytes; flags cleared at start
        start_dl(8'h04);
        chk("rng_ovf_cleared", dn_overflow, 0);
        wr_byte(25'h0010, 8'h11, 1'b1);
        wr_byte(25'h0011, 8'h22, 1'b1);
        wr_byte(25'h4000, 8'h33, 1'b0);
        wr_byte(25'h0013, 8'h44, 1'b1);
        end_dl();
        wait_done("rng");
        chk("rng_flag", dn_range_err, 1);
        chk("rng_count", dn_count, 3);

        // Full FIFO with simultaneous push/pop
        dn_ready = 1'b0;
        start_dl(8'h05);
        chk("full_rng_cleared", dn_range_err, 0);
        for (int i = 0; i < 8; i++) wr_byte(25'(16'h0300 + i), 8'(8'h70 + i), 1'b1);
        dn_ready = 1'b1;
        wr_byte(25'h0308, 8'h78, 1'b1);
        chk("full_no_ovf", dn_overflow, 0);
        chk("full_wait_held", ioctl_wait, 1);
        end_dl();
        wait_done("full");
        chk("full_count", dn_count, 9);

        // Reset mid-download with 4 bytes queued
        dn_ready = 1'b0;
        start_dl(8'h06);
        for (int i = 0; i < 4; i++) wr_byte(25'(16'h0400 + i), 8'(8'h90 + i), 1'b1);
        reset_n = 1'b0;
        exp_q.delete();
        step();
        chk_zero("midrst");
        reset_n  = 1'b1;
        dn_ready = 1'b1;
        step(2);
        wr_byte(25'h0005, 8'h55, 1'b0);
        step(4);
        chk("midrst_no_load", dn_busy, 0);
        chk("midrst_count", dn_count, 0);
        end_dl();
        step(3);
        chk("midrst_no_done", dn_done, 0);
        start_dl(8'h07);
        wr_byte(25'h0020, 8'hC1, 1'b1);
        wr_byte(25'h0021, 8'hC2, 1'b1);
        end_dl();
        wait_done("restart");
        chk("restart_index", dn_index, 8'h07);
        chk("restart_count", dn_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ioctl_dn_buffer.md
# ioctl_dn_buffer

Download-side adapter between the HPS `ioctl_*` byte stream and the `soc` download port (`dn_addr`/`dn_data`/`dn_wr`/`dn_index`). It buffers incoming bytes in a small FIFO and throttles the HPS with `ioctl_wait` when the FIFO nears full. It replays bytes to the core only while the core's write port reports ready. It also drives `dn_busy`, which holds the core in reset until every buffered byte has drained, and reports completion, byte count and error status.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 4.
- `WAIT_THRESH`, 6: occupancy at which `ioctl_wait` asserts; must satisfy 1 ≤ WAIT_THRESH ≤ DEPTH-2.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  HPS download-active level.
- `ioctl_wr`  in  1  single-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_index`  in  8  download target index.
- `ioctl_wait`  out  1  back-pressure to the HPS; registered.
- `dn_addr`  out  14  core write address; registered.
- `dn_data`  out  8  core write data; registered.
- `dn_index`  out  8  index latched at download start.
- `dn_wr`  out  1  core write strobe; one cycle per byte.
- `dn_ready`  in  1  core can accept a write this cycle.
- `dn_busy`  out  1  high from download start until the FIFO is drained.
- `dn_done`  out  1  one-cycle pulse when a download completes.
- `dn_count`  out  16  bytes delivered to the core in the current or last download.
- `dn_overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `dn_range_err`  out  1  sticky: a byte arrived with `ioctl_addr[24:14]` ≠ 0.

## Operation
- **States:**
  - IDLE → LOAD on a rising edge of `ioctl_download`.
  - LOAD → DRAIN when `ioctl_download` falls.
  - DRAIN → DONE when the FIFO is empty and no `dn_wr` is in flight.
  - DONE → IDLE after one cycle.
  - A rising edge of `ioctl_download` while in DRAIN or DONE goes straight to LOAD. FIFO contents are kept and the new download's bytes queue behind them.
- **Entry to LOAD:**
  - Latch `ioctl_index` into `dn_index`.
  - Clear `dn_count`, `dn_overflow` and `dn_range_err`.
  - Set `dn_busy`.
- **Push** happens when `ioctl_wr` is high, `ioctl_download` is high, and the state is LOAD or is entering LOAD.
  - If `ioctl_addr[24:14]` ≠ 0: drop the byte and set `dn_range_err`.
  - Else if the FIFO is full and no pop occurs this cycle: drop the byte and set `dn_overflow`.
  - Otherwise store `{ioctl_addr[13:0], ioctl_dout}`.
  - Strobes with `ioctl_download` low are ignored.
- **Pop** happens when the FIFO is non-empty and `dn_ready` is high.
  - Register the head entry onto `dn_addr`/`dn_data`.
  - Pulse `dn_wr` the following cycle.
  - Increment `dn_count`; it saturates at 0xFFFF.
- **Simultaneous push and pop:**
  - Both take effect in the same cycle.
  - Occupancy is unchanged.
  - A push when full is accepted if a pop occurs in the same cycle.
- **Wrap-around:** read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from an occupancy counter with range 0..DEPTH.
- **Outputs in DONE:**
  - `dn_busy` clears on entry to DONE.
  - `dn_done` is high for exactly the one DONE cycle.
- **`ioctl_wait`:** registered from the next-state occupancy; high when occupancy ≥ WAIT_THRESH, otherwise low.

## Timing
- **Reset values** (with `reset_n` low): state IDLE, FIFO empty, and every output 0. This includes `ioctl_wait`, `dn_wr`, `dn_addr`, `dn_data`, `dn_index`, `dn_busy`, `dn_done`, `dn_count`, `dn_overflow` and `dn_range_err`.
- **Reset mid-download:** the FIFO is discarded and no further `dn_wr` is issued. After reset releases, the block does not enter LOAD until `ioctl_download` is seen low and then high again; a download already in progress is ignored.
- **`dn_busy` start:** asserts in the cycle after the `ioctl_download` rising edge is sampled.
- **Write latency:** a byte pushed in cycle N into an empty FIFO, with `dn_ready` high, produces `dn_wr` in cycle N+2 (pop in N+1, strobe in N+2). Throughput is one byte per cycle.
- **Back-pressure:** `ioctl_wait` reflects occupancy with a one-cycle lag. The DEPTH − WAIT_THRESH entries of slack absorb HPS strobes issued before it sees `ioctl_wait`.
- **Completion:** `dn_done` is issued in the cycle after the last `dn_wr`, or 2 cycles after `ioctl_download` falls if the FIFO is already empty.

## Test plan
- **Basic transfer:** 16 bytes, addr 0..15, data 0xA0+i, index 0x01, `dn_ready` always high.
  - Required: 16 `dn_wr` pulses in order.
  - `dn_index`=0x01, `dn_count`=16, one `dn_done` pulse, `dn_busy` low afterwards.
- **Back-pressure:** `dn_ready` held low while 6 bytes are written back-to-back.
  - Required: `ioctl_wait`=1 the cycle after the 6th push.
  - Raising `dn_ready` drains all 6 bytes, and `ioctl_wait` drops when occupancy reaches 5.
- **Overflow:** `dn_ready` low, 9 strobes ignoring `ioctl_wait`.
  - Required: 8 bytes stored and the 9th dropped; `dn_overflow`=1, `dn_count`=8 after drain.
- **Range error:** a byte at `ioctl_addr`=0x4000 among valid bytes.
  - Required: no `dn_wr` for that byte; `dn_range_err`=1; all other bytes delivered.
- **Full FIFO, simultaneous push/pop:** FIFO full, `dn_ready` high, and a push in the same cycle.
  - Required: the byte is accepted and occupancy stays 8.
- **Reset mid-download:** `reset_n` pulsed low with 4 bytes queued.
  - Required: all outputs 0 and no further `dn_wr`.
  - A new download rising edge restarts cleanly with `dn_count` from 0.
